tlcd_bus_arbiter: RTL and testbench

Owns the character-LCD bus: after reset it issues the fixed power-on command sequence, then arbitrates the shared write-only bus between two requesters (port 0: custom-font loader, port 1: text writer). Each accepted request becomes one fully sequenced LCD write: setup, E strobe, hold and settle gap. Requesters never drive TLCD_* directly; they sit behind this block.

---
 rtl/tlcd_bus_arbiter_if.sv | 29 ++
 rtl/tlcd_bus_arbiter.sv | 175 +++++++++++++++++
 tb/tb_tlcd_bus_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/tlcd_bus_arbiter_if.sv
// rtl/tlcd_bus_arbiter_if.sv - requester handshakes and character-LCD bus bundle
// master: requester/observer side; slave: the arbiter that owns the bus.
interface tlcd_bus_arbiter_if;
  logic       req0;
  logic       req0_rs;
  logic [7:0] req0_data;
  logic       ack0;
  logic       req1;
  logic       req1_rs;
  logic [7:0] req1_data;
  logic       ack1;
  logic       tlcd_e;
  logic       tlcd_rs;
  logic       tlcd_rw;
  logic [7:0] tlcd_data;
  logic       ready;
  logic       busy;
  logic [2:0] state;

  modport master (
    output req0, req0_rs, req0_data, req1, req1_rs, req1_data,
    input  ack0, ack1, tlcd_e, tlcd_rs, tlcd_rw, tlcd_data, ready, busy, state
  );

  modport slave (
    input  req0, req0_rs, req0_data, req1, req1_rs, req1_data,
    output ack0, ack1, tlcd_e, tlcd_rs, tlcd_rw, tlcd_data, ready, busy, state
  );
endinterface

// File: rtl/tlcd_bus_arbiter.sv
// rtl/tlcd_bus_arbiter.sv - LCD power-on sequencer and two-port round-robin write arbiter
// i_resetn is asynchronous and active-high despite its name.
module tlcd_bus_arbiter #(
  parameter int CMD_GAP = 2,
  parameter int CLR_GAP = 20
) (
  input  logic                i_clk,
  input  logic                i_resetn,
  tlcd_bus_arbiter_if.slave   io_bus
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_ARB    = 3'd1,
    S_SETUP  = 3'd2,
    S_STROBE = 3'd3,
    S_HOLD   = 3'd4,
    S_GAP    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    SRC_INIT = 2'd0,
    SRC_P0   = 2'd1,
    SRC_P1   = 2'd2
  } src_t;

  localparam logic [7:0] LP_CMD_GAP_M1 = 8'(CMD_GAP - 1);
  localparam logic [7:0] LP_CLR_GAP_M1 = 8'(CLR_GAP - 1);

  state_t     r_state, w_state_nxt;
  src_t       r_src, w_src_nxt;
  logic [1:0] r_idx, w_idx_nxt;
  logic       r_last_grant, w_last_grant_nxt;
  logic [7:0] r_gap_cnt, w_gap_cnt_nxt;
  logic       r_e, w_e_nxt;
  logic       r_rs, w_rs_nxt;
  logic [7:0] r_data, w_data_nxt;
  logic       r_ack0, w_ack0_nxt;
  logic       r_ack1, w_ack1_nxt;
  logic       r_ready, w_ready_nxt;
  logic [7:0] w_rom_data;
  logic       w_is_clear;

  always_comb begin
    case (r_idx)
      2'd0:    w_rom_data = 8'h38;
      2'd1:    w_rom_data = 8'h0C;
      2'd2:    w_rom_data = 8'h01;
      default: w_rom_data = 8'h06;
    endcase
  end

  assign w_is_clear = !r_rs && (r_data == 8'h01);

  always_ff @(posedge i_clk or posedge i_resetn) begin
    if (i_resetn) begin
      r_state      <= S_INIT;
      r_src        <= SRC_INIT;
      r_idx        <= 2'd0;
      r_last_grant <= 1'b1;
      r_gap_cnt    <= 8'd0;
      r_e          <= 1'b0;
      r_rs         <= 1'b0;
      r_data       <= 8'h00;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_ready      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_src        <= w_src_nxt;
      r_idx        <= w_idx_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_gap_cnt    <= w_gap_cnt_nxt;
      r_e          <= w_e_nxt;
      r_rs         <= w_rs_nxt;
      r_data       <= w_data_nxt;
      r_ack0       <= w_ack0_nxt;
      r_ack1       <= w_ack1_nxt;
      r_ready      <= w_ready_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_src_nxt        = r_src;
    w_idx_nxt        = r_idx;
    w_last_grant_nxt = r_last_grant;
    w_gap_cnt_nxt    = r_gap_cnt;
    w_e_nxt          = r_e;
    w_rs_nxt         = r_rs;
    w_data_nxt       = r_data;
    w_ack0_nxt       = 1'b0;
    w_ack1_nxt       = 1'b0;
    w_ready_nxt      = r_ready;
    case (r_state)
      S_INIT: begin
        w_rs_nxt    = 1'b0;
        w_data_nxt  = w_rom_data;
        w_src_nxt   = SRC_INIT;
        w_state_nxt = S_SETUP;
      end
      S_ARB: begin
        // Skipping the ACK cycle gives the served requester one edge to drop REQ.
        if (!r_ack0 && !r_ack1) begin
          if (io_bus.req0 && (!io_bus.req1 || r_last_grant)) begin
            w_rs_nxt         = io_bus.req0_rs;
            w_data_nxt       = io_bus.req0_data;
            w_src_nxt        = SRC_P0;
            w_last_grant_nxt = 1'b0;
            w_state_nxt      = S_SETUP;
          end else if (io_bus.req1) begin
            w_rs_nxt         = io_bus.req1_rs;
            w_data_nxt       = io_bus.req1_data;
            w_src_nxt        = SRC_P1;
            w_last_grant_nxt = 1'b1;
            w_state_nxt      = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        w_e_nxt     = 1'b1;
        w_state_nxt = S_STROBE;
      end
      S_STROBE: begin
        w_e_nxt     = 1'b0;
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        w_gap_cnt_nxt = w_is_clear ? LP_CLR_GAP_M1 : LP_CMD_GAP_M1;
        w_state_nxt   = S_GAP;
      end
      S_GAP: begin
        if (r_gap_cnt == 8'd0) begin
          case (r_src)
            SRC_INIT: begin
              if (r_idx == 2'd3) begin
                w_ready_nxt = 1'b1;
                w_state_nxt = S_ARB;
              end else begin
                w_idx_nxt   = r_idx + 2'd1;
                w_state_nxt = S_INIT;
              end
            end
            SRC_P0: begin
              w_ack0_nxt  = 1'b1;
              w_state_nxt = S_ARB;
            end
            SRC_P1: begin
              w_ack1_nxt  = 1'b1;
              w_state_nxt = S_ARB;
            end
            default: w_state_nxt = S_ARB;
          endcase
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - 8'd1;
        end
      end
      default: begin
        w_e_nxt     = 1'b0;
        w_state_nxt = S_INIT;
      end
    endcase
  end

  assign io_bus.tlcd_e    = r_e;
  assign io_bus.tlcd_rs   = r_rs;
  assign io_bus.tlcd_rw   = 1'b0;
  assign io_bus.tlcd_data = r_data;
  assign io_bus.ack0      = r_ack0;
  assign io_bus.ack1      = r_ack1;
  assign io_bus.ready     = r_ready;
  assign io_bus.busy      = (r_state != S_ARB);
  assign io_bus.state     = r_state;

endmodule

// File: tb/tb_tlcd_bus_arbiter.sv
// tb/tb_tlcd_bus_arbiter.sv - directed bench for the LCD bus arbiter
// Cycle c is the interval sampled at the falling edge just before rising edge c.
module tb_tlcd_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  tlcd_bus_arbiter_if bus ();

  tlcd_bus_arbiter #(.CMD_GAP(2), .CLR_GAP(20)) dut (
    .i_clk    (clk),
    .i_resetn (rst),
    .io_bus   (bus)
  );

  task automatic pulse_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic reset_to_ready;
    pulse_reset();
    repeat (42) @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    #1;
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d expected 0", bus.state); end
    checks++; if (bus.tlcd_e !== 1'b0) begin errors++; $display("FAIL reset_e got %0b expected 0", bus.tlcd_e); end
    checks++; if (bus.tlcd_rs !== 1'b0 || bus.tlcd_rw !== 1'b0) begin errors++; $display("FAIL reset_rs_rw got %0b%0b expected 00", bus.tlcd_rs, bus.tlcd_rw); end
    checks++; if (bus.tlcd_data !== 8'h00) begin errors++; $display("FAIL reset_data got %0h expected 00", bus.tlcd_data); end
    checks++; if ({bus.ack0, bus.ack1} !== 2'b00) begin errors++; $display("FAIL reset_ack got %0b%0b expected 00", bus.ack0, bus.ack1); end
    checks++; if (bus.ready !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL reset_ready_busy got %0b%0b expected 01", bus.ready, bus.busy); end
  endtask

  task automatic test_init_sequence;
    logic       exp_e;
    logic [7:0] exp_d;
    pulse_reset();
    for (int c = 0; c < 46; c++) begin
      exp_e = (c == 2 || c == 8 || c == 14 || c == 38);
      checks++; if (bus.tlcd_e !== exp_e) begin errors++; $display("FAIL init_e c=%0d got %0b expected %0b", c, bus.tlcd_e, exp_e); end
      if (exp_e) begin
        exp_d = (c == 2) ? 8'h38 : (c == 8) ? 8'h0C : (c == 14) ? 8'h01 : 8'h06;
        checks++; if (bus.tlcd_data !== exp_d || bus.tlcd_rs !== 1'b0) begin errors++; $display("FAIL init_data c=%0d got %0b/%0h expected 0/%0h", c, bus.tlcd_rs, bus.tlcd_data, exp_d); end
      end
      checks++; if (bus.ready !== (c >= 42)) begin errors++; $display("FAIL init_ready c=%0d got %0b expected %0b", c, bus.ready, (c >= 42)); end
      checks++; if ({bus.ack0, bus.ack1} !== 2'b00) begin errors++; $display("FAIL init_ack c=%0d got %0b%0b expected 00", c, bus.ack0, bus.ack1); end
      @(negedge clk);
    end
  endtask

  task automatic test_single_write;
    logic [2:0] exp_s;
    reset_to_ready();
    bus.req0 = 1'b1; bus.req0_rs = 1'b1; bus.req0_data = 8'h41;
    for (int k = 0; k < 10; k++) begin
      case (k)
        1: exp_s = 3'd2;
        2: exp_s = 3'd3;
        3: exp_s = 3'd4;
        4, 5: exp_s = 3'd5;
        default: exp_s = 3'd1;
      endcase
      checks++; if (bus.state !== exp_s) begin errors++; $display("FAIL single_state k=%0d got %0d expected %0d", k, bus.state, exp_s); end
      checks++; if (bus.tlcd_e !== (k == 2)) begin errors++; $display("FAIL single_e k=%0d got %0b expected %0b", k, bus.tlcd_e, (k == 2)); end
      checks++; if (bus.ack0 !== (k == 6) || bus.ack1 !== 1'b0) begin errors++; $display("FAIL single_ack k=%0d got %0b%0b expected %0b0", k, bus.ack0, bus.ack1, (k == 6)); end
      if (k == 2) begin
        checks++; if (bus.tlcd_rs !== 1'b1 || bus.tlcd_data !== 8'h41) begin errors++; $display("FAIL single_data got %0b/%0h expected 1/41", bus.tlcd_rs, bus.tlcd_data); end
      end
      if (bus.ack0) bus.req0 = 1'b0;
      @(negedge clk);
    end
    bus.req0 = 1'b0;
    checks++; if (bus.tlcd_rs !== 1'b1 || bus.tlcd_data !== 8'h41 || bus.busy !== 1'b0) begin errors++; $display("FAIL single_hold got %0b/%0h busy %0b expected 1/41 busy 0", bus.tlcd_rs, bus.tlcd_data, bus.busy); end
  endtask

  task automatic test_round_robin;
    logic [7:0] exp_d;
    reset_to_ready();
    bus.req0 = 1'b1; bus.req0_rs = 1'b1; bus.req0_data = 8'hAA;
    bus.req1 = 1'b1; bus.req1_rs = 1'b1; bus.req1_data = 8'h55;
    for (int k = 0; k < 28; k++) begin
      checks++; if (bus.tlcd_e !== (k == 2 || k == 9 || k == 16 || k == 23)) begin errors++; $display("FAIL rr_e k=%0d got %0b", k, bus.tlcd_e); end
      if (bus.tlcd_e) begin
        exp_d = (k == 9 || k == 23) ? 8'h55 : 8'hAA;
        checks++; if (bus.tlcd_data !== exp_d) begin errors++; $display("FAIL rr_data k=%0d got %0h expected %0h", k, bus.tlcd_data, exp_d); end
      end
      checks++; if (bus.ack0 !== (k == 6 || k == 20)) begin errors++; $display("FAIL rr_ack0 k=%0d got %0b", k, bus.ack0); end
      checks++; if (bus.ack1 !== (k == 13 || k == 27)) begin errors++; $display("FAIL rr_ack1 k=%0d got %0b", k, bus.ack1); end
      if (k == 27) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
      @(negedge clk);
    end
    checks++; if (bus.state !== 3'd1 || bus.busy !== 1'b0) begin errors++; $display("FAIL rr_idle got state %0d busy %0b expected 1 0", bus.state, bus.busy); end
  endtask

  task automatic test_clear_gap;
    reset_to_ready();
    bus.req1 = 1'b1; bus.req1_rs = 1'b0; bus.req1_data = 8'h01;
    for (int k = 0; k < 27; k++) begin
      checks++; if (bus.tlcd_e !== (k == 2)) begin errors++; $display("FAIL clr_e k=%0d got %0b expected %0b", k, bus.tlcd_e, (k == 2)); end
      checks++; if (bus.ack1 !== (k == 24) || bus.ack0 !== 1'b0) begin errors++; $display("FAIL clr_ack k=%0d got %0b%0b expected 0%0b", k, bus.ack0, bus.ack1, (k == 24)); end
      if (k == 4 || k == 23) begin
        checks++; if (bus.state !== 3'd5) begin errors++; $display("FAIL clr_gap_state k=%0d got %0d expected 5", k, bus.state); end
      end
      if (k == 24) begin
        checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL clr_end_state got %0d expected 1", bus.state); end
      end
      if (bus.ack1) bus.req1 = 1'b0;
      @(negedge clk);
    end
    bus.req1 = 1'b0;
  endtask

  task automatic test_init_request;
    pulse_reset();
    for (int c = 0; c < 51; c++) begin
      if (c == 10) begin
        bus.req0 = 1'b1; bus.req0_rs = 1'b1; bus.req0_data = 8'h5A;
      end
      checks++; if (bus.tlcd_e !== (c == 2 || c == 8 || c == 14 || c == 38 || c == 44)) begin errors++; $display("FAIL ireq_e c=%0d got %0b", c, bus.tlcd_e); end
      if (c == 38) begin
        checks++; if (bus.tlcd_data !== 8'h06 || bus.tlcd_rs !== 1'b0) begin errors++; $display("FAIL ireq_init_data got %0b/%0h expected 0/06", bus.tlcd_rs, bus.tlcd_data); end
      end
      if (c == 44) begin
        checks++; if (bus.tlcd_data !== 8'h5A || bus.tlcd_rs !== 1'b1) begin errors++; $display("FAIL ireq_data got %0b/%0h expected 1/5a", bus.tlcd_rs, bus.tlcd_data); end
      end
      if (c == 43) begin
        checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL ireq_setup got %0d expected 2", bus.state); end
      end
      checks++; if (bus.ack0 !== (c == 48) || bus.ack1 !== 1'b0) begin errors++; $display("FAIL ireq_ack c=%0d got %0b%0b expected %0b0", c, bus.ack0, bus.ack1, (c == 48)); end
      if (bus.ack0) bus.req0 = 1'b0;
      @(negedge clk);
    end
    bus.req0 = 1'b0;
  endtask

  task automatic test_reset_mid_write;
    reset_to_ready();
    bus.req1 = 1'b1; bus.req1_rs = 1'b1; bus.req1_data = 8'h33;
    repeat (2) @(negedge clk);
    checks++; if (bus.tlcd_e !== 1'b1 || bus.state !== 3'd3) begin errors++; $display("FAIL mid_strobe got e %0b state %0d expected 1 3", bus.tlcd_e, bus.state); end
    rst = 1'b1;
    #1;
    checks++; if (bus.tlcd_e !== 1'b0 || bus.state !== 3'd0) begin errors++; $display("FAIL mid_abort got e %0b state %0d expected 0 0", bus.tlcd_e, bus.state); end
    checks++; if (bus.tlcd_data !== 8'h00 || bus.tlcd_rs !== 1'b0) begin errors++; $display("FAIL mid_bus got %0b/%0h expected 0/00", bus.tlcd_rs, bus.tlcd_data); end
    checks++; if (bus.ready !== 1'b0 || bus.busy !== 1'b1 || bus.ack1 !== 1'b0) begin errors++; $display("FAIL mid_flags got ready %0b busy %0b ack1 %0b expected 0 1 0", bus.ready, bus.busy, bus.ack1); end
    bus.req1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 44; c++) begin
      checks++; if (bus.ack1 !== 1'b0 || bus.ack0 !== 1'b0) begin errors++; $display("FAIL mid_noack c=%0d got %0b%0b expected 00", c, bus.ack0, bus.ack1); end
      if (c == 2) begin
        checks++; if (bus.tlcd_e !== 1'b1 || bus.tlcd_data !== 8'h38) begin errors++; $display("FAIL mid_restart got e %0b data %0h expected 1 38", bus.tlcd_e, bus.tlcd_data); end
      end
      if (c == 42) begin
        checks++; if (bus.ready !== 1'b1 || bus.state !== 3'd1) begin errors++; $display("FAIL mid_ready got %0b state %0d expected 1 1", bus.ready, bus.state); end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    bus.req0 = 1'b0; bus.req0_rs = 1'b0; bus.req0_data = 8'h00;
    bus.req1 = 1'b0; bus.req1_rs = 1'b0; bus.req1_data = 8'h00;
    test_reset();
    test_init_sequence();
    test_single_write();
    test_round_robin();
    test_clear_gap();
    test_init_request();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
